bridge_to_outside_q: RTL and testbench



---
 rtl/bridge_to_outside_q_if.sv | 52 +++++
 rtl/bridge_to_outside_q.sv | 258 +++++++++++++++++++++++++
 tb/tb_bridge_to_outside_q.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_to_outside_q_if.sv
`default_nettype none
// ============================================================================
// Module   : bridge_to_outside_q_if
// Brief    : Core-side request/response and outside-bus signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface bridge_to_outside_q_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              ext_idx_ld;
  logic [IDX_W-1:0]  ext_cpu_index_in;
  logic              idx_valid;
  logic              ext_next_cpu_q;
  logic              ext_next_cpu_e;
  logic              ext_dispatcher_q;
  logic              ext_read_q;
  logic              ext_write_q;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_oe;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_dn;
  logic              disp_online;

  // The bridge is the master toward the outside bus.
  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    input  ext_idx_ld, ext_cpu_index_in, ext_next_cpu_q, ext_rdata, ext_dn,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, idx_valid,
    output ext_next_cpu_e, ext_dispatcher_q, ext_read_q, ext_write_q,
    output ext_addr, ext_wdata, ext_oe, disp_online
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    output ext_idx_ld, ext_cpu_index_in, ext_next_cpu_q, ext_rdata, ext_dn,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, idx_valid,
    input  ext_next_cpu_e, ext_dispatcher_q, ext_read_q, ext_write_q,
    input  ext_addr, ext_wdata, ext_oe, disp_online
  );
endinterface
`default_nettype wire

// File: rtl/bridge_to_outside_q.sv
`default_nettype none
// ============================================================================
// Module   : bridge_to_outside_q
// Brief    : FIFO-buffered CPU bridge onto a token-ring arbitrated outside bus.
// Revision : 1.0 - initial release
// ============================================================================
module bridge_to_outside_q #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 8,
  parameter int DEPTH     = 4,
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  bridge_to_outside_q_if.master bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_BST_W = $clog2(BURST_MAX + 1);
  localparam int c_TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(DEPTH);
  localparam logic [c_BST_W-1:0] c_BURST_LIM = c_BST_W'(BURST_MAX);
  localparam logic [c_TMO_W-1:0] c_TMO_LOAD  = c_TMO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_TOKEN = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT_DN    = 3'd3,
    S_RELEASE    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic               r_idx_valid;
  logic [IDX_W-1:0]   r_cpu_index;

  logic               r_mem_we    [DEPTH];
  logic [ADDR_W-1:0]  r_mem_addr  [DEPTH];
  logic [DATA_W-1:0]  r_mem_wdata [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_count_nxt;
  logic               r_req_ready;
  logic               w_push;
  logic               w_pop;
  logic               w_left;
  logic               w_grant;

  logic               r_disp_q,   w_disp_q_nxt;
  logic               r_online,   w_online_nxt;
  logic               r_rd_q,     w_rd_q_nxt;
  logic               r_wr_q,     w_wr_q_nxt;
  logic [ADDR_W-1:0]  r_addr,     w_addr_nxt;
  logic [DATA_W-1:0]  r_wdata,    w_wdata_nxt;
  logic               r_oe,       w_oe_nxt;
  logic               r_tok_e,    w_tok_e_nxt;
  logic               r_rsp_v,    w_rsp_v_nxt;
  logic [DATA_W-1:0]  r_rsp_d,    w_rsp_d_nxt;
  logic               r_rsp_e,    w_rsp_e_nxt;
  logic [c_BST_W-1:0] r_burst,    w_burst_nxt;
  logic [c_BST_W-1:0] w_burst_inc;
  logic [c_TMO_W-1:0] r_timer,    w_timer_nxt;

  // Only the first enumeration strobe after reset sets our ring index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx_valid <= 1'b0;
      r_cpu_index <= '0;
    end else if (bus.ext_idx_ld && !r_idx_valid) begin
      r_idx_valid <= 1'b1;
      r_cpu_index <= bus.ext_cpu_index_in;
    end
  end

  assign w_grant = bus.ext_next_cpu_q && r_idx_valid &&
                   (bus.ext_cpu_index_in == r_cpu_index);

  assign w_push = bus.req_valid && r_req_ready;
  assign w_left = (r_count > c_CNT_W'(1)) || w_push;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_we[r_wr_ptr]    <= bus.req_we;
      r_mem_addr[r_wr_ptr]  <= bus.req_addr;
      r_mem_wdata[r_wr_ptr] <= bus.req_wdata;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
      2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count     <= w_count_nxt;
      r_req_ready <= (w_count_nxt != c_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_burst_inc = r_burst + c_BST_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_disp_q_nxt = r_disp_q;
    w_online_nxt = r_online;
    w_rd_q_nxt   = r_rd_q;
    w_wr_q_nxt   = r_wr_q;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_oe_nxt     = r_oe;
    w_tok_e_nxt  = 1'b0;
    w_rsp_v_nxt  = 1'b0;
    w_rsp_d_nxt  = '0;
    w_rsp_e_nxt  = 1'b0;
    w_burst_nxt  = r_burst;
    w_timer_nxt  = r_timer;

    case (r_state)
      S_IDLE: begin
        // An unsolicited token is passed straight on; one that finds work is used.
        if (w_grant) begin
          if (r_count == '0) begin
            w_state_nxt = S_RELEASE;
          end else begin
            w_online_nxt = 1'b1;
            w_burst_nxt  = '0;
            w_state_nxt  = S_ISSUE;
          end
        end else if (r_count != '0) begin
          w_disp_q_nxt = 1'b1;
          w_state_nxt  = S_WAIT_TOKEN;
        end
      end

      S_WAIT_TOKEN: begin
        w_disp_q_nxt = 1'b1;
        if (w_grant) begin
          w_online_nxt = 1'b1;
          w_disp_q_nxt = 1'b0;
          w_burst_nxt  = '0;
          w_state_nxt  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        w_addr_nxt  = r_mem_addr[r_rd_ptr];
        w_wdata_nxt = r_mem_wdata[r_rd_ptr];
        w_oe_nxt    = 1'b1;
        w_wr_q_nxt  = r_mem_we[r_rd_ptr];
        w_rd_q_nxt  = !r_mem_we[r_rd_ptr];
        w_timer_nxt = c_TMO_LOAD;
        w_state_nxt = S_WAIT_DN;
      end

      S_WAIT_DN: begin
        // Done is tested before expiry so a done on the last cycle still succeeds.
        if (bus.ext_dn) begin
          w_rd_q_nxt  = 1'b0;
          w_wr_q_nxt  = 1'b0;
          w_pop       = 1'b1;
          w_rsp_v_nxt = 1'b1;
          w_rsp_d_nxt = r_rd_q ? bus.ext_rdata : '0;
          w_burst_nxt = w_burst_inc;
          w_state_nxt = (w_left && (w_burst_inc < c_BURST_LIM)) ? S_ISSUE : S_RELEASE;
        end else if (r_timer == '0) begin
          w_rd_q_nxt  = 1'b0;
          w_wr_q_nxt  = 1'b0;
          w_pop       = 1'b1;
          w_rsp_v_nxt = 1'b1;
          w_rsp_e_nxt = 1'b1;
          w_state_nxt = S_RELEASE;
        end else begin
          w_timer_nxt = r_timer - c_TMO_W'(1);
        end
      end

      S_RELEASE: begin
        w_tok_e_nxt  = 1'b1;
        w_online_nxt = 1'b0;
        w_oe_nxt     = 1'b0;
        w_state_nxt  = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_q <= 1'b0;
      r_online <= 1'b0;
      r_rd_q   <= 1'b0;
      r_wr_q   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_oe     <= 1'b0;
      r_tok_e  <= 1'b0;
      r_rsp_v  <= 1'b0;
      r_rsp_d  <= '0;
      r_rsp_e  <= 1'b0;
      r_burst  <= '0;
      r_timer  <= '0;
    end else begin
      r_disp_q <= w_disp_q_nxt;
      r_online <= w_online_nxt;
      r_rd_q   <= w_rd_q_nxt;
      r_wr_q   <= w_wr_q_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_oe     <= w_oe_nxt;
      r_tok_e  <= w_tok_e_nxt;
      r_rsp_v  <= w_rsp_v_nxt;
      r_rsp_d  <= w_rsp_d_nxt;
      r_rsp_e  <= w_rsp_e_nxt;
      r_burst  <= w_burst_nxt;
      r_timer  <= w_timer_nxt;
    end
  end

  assign bus.req_ready        = r_req_ready;
  assign bus.rsp_valid        = r_rsp_v;
  assign bus.rsp_rdata        = r_rsp_d;
  assign bus.rsp_err          = r_rsp_e;
  assign bus.idx_valid        = r_idx_valid;
  assign bus.ext_next_cpu_e   = r_tok_e;
  assign bus.ext_dispatcher_q = r_disp_q;
  assign bus.ext_read_q       = r_rd_q;
  assign bus.ext_write_q      = r_wr_q;
  assign bus.ext_addr         = r_addr;
  assign bus.ext_wdata        = r_wdata;
  assign bus.ext_oe           = r_oe;
  assign bus.disp_online      = r_online;

endmodule
`default_nettype wire

// File: tb/tb_bridge_to_outside_q.sv
`default_nettype none
// ============================================================================
// Module   : tb_bridge_to_outside_q
// Brief    : Scoreboard bench for bridge_to_outside_q (DEPTH 4, burst 2, timeout 10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bridge_to_outside_q;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int IDX_W     = 8;
  localparam int DEPTH     = 4;
  localparam int BURST_MAX = 2;
  localparam int TIMEOUT   = 10;

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} xfer_t;
  typedef struct packed {logic err; logic [31:0] rdata;} rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0, tok_cnt = 0, rsp_cnt = 0, stb_cnt = 0, t_stb = 0, t_rsp = 0;
  bit   dn_en  = 1'b1;
  int   dn_dly = 3;
  xfer_t xq[$];
  rsp_t  rq[$];

  bridge_to_outside_q_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  bridge_to_outside_q #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W),
    .DEPTH(DEPTH), .BURST_MAX(BURST_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0F0F);
  endfunction

  function automatic logic outs_or();
    return |{bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.idx_valid,
             bus.ext_next_cpu_e, bus.ext_dispatcher_q, bus.ext_read_q, bus.ext_write_q,
             bus.ext_addr, bus.ext_wdata, bus.ext_oe, bus.disp_online};
  endfunction

  // Outside-bus responder: answers each strobe after dn_dly falling edges.
  initial begin
    int wc = 0;
    bus.ext_dn    = 1'b0;
    bus.ext_rdata = '0;
    forever begin
      @(negedge clk);
      bus.ext_dn = 1'b0;
      if ((bus.ext_read_q || bus.ext_write_q) && dn_en) begin
        wc++;
        if (wc >= dn_dly) begin
          bus.ext_dn    = 1'b1;
          bus.ext_rdata = rd_model(bus.ext_addr);
          wc = 0;
        end
      end else begin
        wc = 0;
      end
    end
  end

  // Monitor: transfer and response scoreboards, token pulse counting.
  initial begin
    logic  prev_stb = 1'b0;
    logic  stb;
    xfer_t x;
    rsp_t  r;
    forever begin
      @(posedge clk);
      #1;
      stb = bus.ext_read_q | bus.ext_write_q;
      if (stb && !prev_stb) begin
        stb_cnt++;
        t_stb = cyc;
        chk_val("stb_exclusive", 64'(bus.ext_read_q & bus.ext_write_q), 0);
        chk_val("stb_online", 64'(bus.disp_online), 1);
        chk_val("xfer_expected", 64'(xq.size() != 0), 1);
        if (xq.size() != 0) begin
          x = xq.pop_front();
          chk_val("xfer_we", 64'(bus.ext_write_q), 64'(x.we));
          chk_val("xfer_addr", 64'(bus.ext_addr), 64'(x.addr));
          if (x.we) chk_val("xfer_wdata", 64'(bus.ext_wdata), 64'(x.wdata));
          chk_val("xfer_oe", 64'(bus.ext_oe), 1);
        end
      end
      prev_stb = stb;
      if (bus.rsp_valid) begin
        rsp_cnt++;
        t_rsp = cyc;
        chk_val("rsp_stb_low", 64'(stb), 0);
        chk_val("rsp_expected", 64'(rq.size() != 0), 1);
        if (rq.size() != 0) begin
          r = rq.pop_front();
          chk_val("rsp_err", 64'(bus.rsp_err), 64'(r.err));
          chk_val("rsp_rdata", 64'(bus.rsp_rdata), 64'(r.rdata));
        end
      end
      if (bus.ext_next_cpu_e) tok_cnt++;
    end
  end

  task automatic push_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic err);
    int   n = 0;
    rsp_t r;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    chk_val("push_accept", 64'(bus.req_ready), 1);
    xq.push_back('{we: we, addr: addr, wdata: wdata});
    r.err   = err;
    r.rdata = (err || we) ? 32'h0 : rd_model(addr);
    rq.push_back(r);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic grant(input logic [7:0] idx);
    bus.ext_cpu_index_in = idx;
    bus.ext_next_cpu_q   = 1'b1;
    @(negedge clk);
    bus.ext_next_cpu_q   = 1'b0;
  endtask

  task automatic wait_dq();
    int n = 0;
    while (!bus.ext_dispatcher_q && n < 50) begin @(negedge clk); n++; end
    chk_val("dq_raised", 64'(bus.ext_dispatcher_q), 1);
  endtask

  task automatic wait_tok(input int target);
    int n = 0;
    while (tok_cnt < target && n < 200) begin @(negedge clk); n++; end
    chk_val("tok_count", 64'(tok_cnt), 64'(target));
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 200) begin @(negedge clk); n++; end
    chk_val("rsp_count", 64'(rsp_cnt), 64'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tok0, rsp0, stb0, n;
    rst_n = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.ext_idx_ld = 1'b0; bus.ext_cpu_index_in = '0; bus.ext_next_cpu_q = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_val("reset_outputs", 64'(outs_or()), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_val("ready_after_reset", 64'(bus.req_ready), 1);
    chk_val("idx_valid_reset", 64'(bus.idx_valid), 0);

    // Index capture: first strobe wins.
    bus.ext_cpu_index_in = 8'd5; bus.ext_idx_ld = 1'b1;
    @(negedge clk); bus.ext_idx_ld = 1'b0;
    bus.ext_cpu_index_in = 8'd7; bus.ext_idx_ld = 1'b1;
    @(negedge clk); bus.ext_idx_ld = 1'b0;
    chk_val("idx_valid", 64'(bus.idx_valid), 1);
    grant(8'd7);
    repeat (4) @(negedge clk);
    chk_val("grant7_ignored", 64'(tok_cnt), 0);
    chk_val("grant7_offline", 64'(bus.disp_online), 0);
    grant(8'd5);
    repeat (3) @(negedge clk);
    chk_val("empty_grant_pass", 64'(tok_cnt), 1);

    // Single read.
    push_req(1'b0, 32'h100, 32'h0, 1'b0);
    chk_val("dq_before", 64'(bus.ext_dispatcher_q), 0);
    @(negedge clk);
    chk_val("dq_one_cycle", 64'(bus.ext_dispatcher_q), 1);
    grant(8'd5);
    wait_rsp(1);
    wait_tok(2);
    chk_val("read_offline", 64'(bus.disp_online), 0);

    // Burst limit and full FIFO refilled while draining.
    tok0 = tok_cnt; rsp0 = rsp_cnt;
    for (int i = 0; i < 4; i++) push_req(1'b1, 32'h200 + 32'(i * 4), $urandom, 1'b0);
    chk_val("full_ready_low", 64'(bus.req_ready), 0);
    fork
      push_req(1'b1, 32'h210, $urandom, 1'b0);
      begin wait_dq(); grant(8'd5); end
    join
    chk_val("refill_ready_low", 64'(bus.req_ready), 0);
    wait_tok(tok0 + 1);
    chk_val("burst1_len", 64'(rsp_cnt - rsp0), 2);
    wait_dq();
    grant(8'd5);
    wait_tok(tok0 + 2);
    chk_val("burst2_len", 64'(rsp_cnt - rsp0), 4);
    wait_dq();
    grant(8'd5);
    wait_tok(tok0 + 3);
    chk_val("burst3_len", 64'(rsp_cnt - rsp0), 5);
    chk_val("queues_drained", 64'(xq.size() + rq.size()), 0);

    // Timeout, then a done arriving exactly on the expiry cycle.
    dn_en = 1'b0;
    tok0 = tok_cnt; rsp0 = rsp_cnt;
    push_req(1'b0, 32'h300, 32'h0, 1'b1);
    wait_dq(); grant(8'd5);
    wait_rsp(rsp0 + 1);
    chk_val("timeout_latency", 64'(t_rsp - t_stb), 64'(TIMEOUT + 1));
    wait_tok(tok0 + 1);
    dn_en = 1'b1; dn_dly = TIMEOUT + 1;
    push_req(1'b0, 32'h304, 32'h0, 1'b0);
    wait_dq(); grant(8'd5);
    wait_rsp(rsp0 + 2);
    chk_val("late_done_latency", 64'(t_rsp - t_stb), 64'(TIMEOUT + 1));
    wait_tok(tok0 + 2);

    // Reset while waiting for done.
    dn_en = 1'b0; dn_dly = 3;
    stb0 = stb_cnt;
    push_req(1'b0, 32'h400, 32'h0, 1'b0);
    push_req(1'b1, 32'h404, 32'h1234, 1'b0);
    wait_dq(); grant(8'd5);
    n = 0;
    while (stb_cnt == stb0 && n < 50) begin @(negedge clk); n++; end
    chk_val("mid_strobe_seen", 64'(stb_cnt - stb0), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_val("mid_reset_outputs", 64'(outs_or()), 0);
    chk_val("mid_reset_idx", 64'(bus.idx_valid), 0);
    xq.delete(); rq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tok0 = tok_cnt; rsp0 = rsp_cnt;
    dn_en = 1'b1;
    repeat (20) @(negedge clk);
    chk_val("post_reset_no_rsp", 64'(rsp_cnt), 64'(rsp0));
    chk_val("post_reset_no_tok", 64'(tok_cnt), 64'(tok0));
    chk_val("post_reset_empty", 64'(bus.ext_dispatcher_q), 0);
    chk_val("post_reset_ready", 64'(bus.req_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
